// File: rtl/reg_bank_onehot.sv
// Sixteen 32-bit registers written and read through one-hot Rin/Rout enables; BAout zeroes an R0 read.
// Define REG_BANK_ERR_EN to add multi-hot detection (sticky error flags, write suppression, RegOutValid=0).
module reg_bank_onehot (
   input  logic        clock,
   input  logic        clear,
   input  logic [15:0] Rin,
   input  logic [15:0] Rout,
   input  logic        BAout,
   input  logic [31:0] BusMuxOut,
   output logic [31:0] RegOut,
   output logic        RegOutValid,
   output logic [3:0]  RoutIdx,
   output logic        ErrMultiRin,
   output logic        ErrMultiRout
);

   logic [31:0] regs [16];
   logic [3:0]  idx;
   logic        wr_block;

`ifdef REG_BANK_ERR_EN
   // A vector is multi-hot when clearing its lowest set bit leaves something behind.
   logic rin_multi;
   logic rout_multi;

   assign rin_multi  = |(Rin & (Rin - 16'd1));
   assign rout_multi = |(Rout & (Rout - 16'd1));
   assign wr_block   = rin_multi;

   always_ff @(posedge clock) begin
      if (clear) begin
         ErrMultiRin  <= 1'b0;
         ErrMultiRout <= 1'b0;
      end else begin
         if (rin_multi)  ErrMultiRin  <= 1'b1;
         if (rout_multi) ErrMultiRout <= 1'b1;
      end
   end
`else
   assign wr_block     = 1'b0;
   assign ErrMultiRin  = 1'b0;
   assign ErrMultiRout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else if (!wr_block) begin
         for (int i = 0; i < 16; i++) begin
            if (Rin[i]) regs[i] <= BusMuxOut;
         end
      end
   end

   // Descending scan so the lowest set bit is the last assignment and wins.
   always_comb begin
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (Rout[i]) idx = 4'(i);
      end
   end

   always_comb begin
      RoutIdx = idx;
      RegOut  = '0;
      if (|Rout && !(BAout && Rout[0])) RegOut = regs[idx];
`ifdef REG_BANK_ERR_EN
      RegOutValid = |Rout && !rout_multi;
`else
      RegOutValid = |Rout;
`endif
   end

endmodule

// File: tb/tb_reg_bank_onehot.sv
// Randomised bench for reg_bank_onehot: array-based reference model, per-cycle compare, directed literal checks.
module tb_reg_bank_onehot;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic [15:0] Rin = '0;
   logic [15:0] Rout = '0;
   logic        BAout = 1'b0;
   logic [31:0] BusMuxOut = '0;
   logic [31:0] RegOut;
   logic        RegOutValid;
   logic [3:0]  RoutIdx;
   logic        ErrMultiRin;
   logic        ErrMultiRout;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

`ifdef REG_BANK_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic [31:0] mreg [16];
   logic        m_err_rin  = 1'b0;
   logic        m_err_rout = 1'b0;

   reg_bank_onehot dut (
      .clock(clock), .clear(clear), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .BusMuxOut(BusMuxOut), .RegOut(RegOut), .RegOutValid(RegOutValid),
      .RoutIdx(RoutIdx), .ErrMultiRin(ErrMultiRin), .ErrMultiRout(ErrMultiRout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers as a plain array, updated from the rules at each rising edge.
   always @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) mreg[i] = '0;
         m_err_rin  = 1'b0;
         m_err_rout = 1'b0;
      end else begin
         if (ERR && $countones(Rin) >= 2) m_err_rin = 1'b1;
         if (ERR && $countones(Rout) >= 2) m_err_rout = 1'b1;
         if (!(ERR && $countones(Rin) >= 2)) begin
            for (int i = 0; i < 16; i++) if (Rin[i]) mreg[i] = BusMuxOut;
         end
      end
   end

   // Compare process: inputs change at the falling edge, outputs are checked 3 time units later.
   always @(negedge clock) begin
      #3;
      if (checking) begin
         int          e_idx;
         logic [31:0] e_out;
         logic        e_vld;
         e_idx = 0;
         for (int i = 15; i >= 0; i--) if (Rout[i]) e_idx = i;
         if (Rout == 0)                 e_out = '0;
         else if (BAout && e_idx == 0)  e_out = '0;
         else                           e_out = mreg[e_idx];
         e_vld = ($countones(Rout) == 1) || ($countones(Rout) >= 2 && !ERR);
         chk("model RegOut", RegOut, e_out);
         chk("model RoutIdx", {28'd0, RoutIdx}, e_idx);
         chk("model RegOutValid", {31'd0, RegOutValid}, {31'd0, e_vld});
         chk("model ErrMultiRin", {31'd0, ErrMultiRin}, {31'd0, m_err_rin});
         chk("model ErrMultiRout", {31'd0, ErrMultiRout}, {31'd0, m_err_rout});
      end
   end

   task automatic cyc(input logic c, input logic [15:0] ri, input logic [15:0] ro,
                      input logic ba, input logic [31:0] bus);
      @(negedge clock);
      clear = c; Rin = ri; Rout = ro; BAout = ba; BusMuxOut = bus;
      #3;
   endtask

   function automatic logic [15:0] rand_vec();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      return 16'h0000;
      else if (sel <= 7) return 16'h0001 << $urandom_range(0, 15);
      else               return 16'($urandom);
   endfunction

   initial begin
      cyc(1, 16'h0, 16'h0, 0, 32'h0);
      checking = 1'b1;

      // Reset state
      cyc(0, 16'h0, 16'h0020, 0, 32'h0);
      chk("reset R5", RegOut, 32'h0);
      chk("reset valid", {31'd0, RegOutValid}, 32'd1);
      chk("reset ErrMultiRin", {31'd0, ErrMultiRin}, 32'd0);
      chk("reset ErrMultiRout", {31'd0, ErrMultiRout}, 32'd0);

      // Basic write/read of R5
      cyc(0, 16'h0020, 16'h0, 0, 32'hDEADBEEF);
      cyc(0, 16'h0, 16'h0020, 0, 32'h0);
      chk("R5 data", RegOut, 32'hDEADBEEF);
      chk("R5 idx", {28'd0, RoutIdx}, 32'd5);
      chk("R5 valid", {31'd0, RegOutValid}, 32'd1);

      // BAout on R0
      cyc(0, 16'h0001, 16'h0, 0, 32'h12345678);
      cyc(0, 16'h0, 16'h0001, 0, 32'h0);
      chk("R0 plain", RegOut, 32'h12345678);
      cyc(0, 16'h0, 16'h0001, 1, 32'h0);
      chk("R0 BAout data", RegOut, 32'h0);
      chk("R0 BAout valid", {31'd0, RegOutValid}, 32'd1);
      cyc(0, 16'h0, 16'h0001, 0, 32'h0);
      chk("R0 retained", RegOut, 32'h12345678);

      // Read during write of R3
      cyc(0, 16'h0008, 16'h0, 0, 32'h11);
      cyc(0, 16'h0008, 16'h0008, 0, 32'h22);
      chk("R3 old value", RegOut, 32'h11);
      cyc(0, 16'h0, 16'h0008, 0, 32'h0);
      chk("R3 new value", RegOut, 32'h22);

      // Multi-hot Rin
      cyc(0, 16'h0006, 16'h0, 0, 32'hAAAA5555);
      cyc(0, 16'h0, 16'h0002, 0, 32'h0);
      chk("multi Rin R1", RegOut, ERR ? 32'h0 : 32'hAAAA5555);
      chk("multi Rin flag", {31'd0, ErrMultiRin}, ERR ? 32'd1 : 32'd0);
      cyc(0, 16'h0, 16'h0004, 0, 32'h0);
      chk("multi Rin R2", RegOut, ERR ? 32'h0 : 32'hAAAA5555);

      // Multi-hot Rout
      cyc(0, 16'h0100, 16'h0, 0, 32'h8);
      cyc(0, 16'h0200, 16'h0, 0, 32'h9);
      cyc(0, 16'h0, 16'h0300, 0, 32'h0);
      chk("multi Rout data", RegOut, 32'h8);
      chk("multi Rout idx", {28'd0, RoutIdx}, 32'd8);
      chk("multi Rout valid", {31'd0, RegOutValid}, ERR ? 32'd0 : 32'd1);
      cyc(0, 16'h0, 16'h0, 0, 32'h0);
      chk("multi Rout flag", {31'd0, ErrMultiRout}, ERR ? 32'd1 : 32'd0);
      chk("idle data", RegOut, 32'h0);
      chk("idle valid", {31'd0, RegOutValid}, 32'd0);

      // clear beats a same-cycle write
      cyc(1, 16'h8000, 16'h0, 0, 32'hFFFFFFFF);
      cyc(0, 16'h0, 16'h8000, 0, 32'h0);
      chk("clear R15", RegOut, 32'h0);
      chk("clear ErrMultiRin", {31'd0, ErrMultiRin}, 32'd0);
      chk("clear ErrMultiRout", {31'd0, ErrMultiRout}, 32'd0);
      cyc(0, 16'h0, 16'h0020, 0, 32'h0);
      chk("clear R5", RegOut, 32'h0);

      // clear beats a same-cycle multi-hot event
      cyc(1, 16'h0011, 16'h0011, 0, 32'h5);
      cyc(0, 16'h0, 16'h0010, 0, 32'h0);
      chk("clear vs multi flag", {31'd0, ErrMultiRin | ErrMultiRout}, 32'd0);
      chk("clear vs multi R4", RegOut, 32'h0);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) == 0), rand_vec(), rand_vec(),
             ($urandom_range(0, 3) == 0), $urandom);
      end

      @(negedge clock);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
